// File: rtl/instruction_fetch.sv
// Fetch stage of the 5-stage MIPS pipeline: PC, instruction memory and IF/ID register.
// Applies decode redirects, load-use stalls and HALT; memory is loadable via a write port.
module instruction_fetch #(
  parameter int          NB_ADDR = 8,
  parameter logic [31:0] NOP     = 32'h00000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [31:0]        i_jump_addr,
  input  logic               i_halt,
  input  logic               i_inst_write_enable,
  input  logic [NB_ADDR-1:0] i_inst_write_addr,
  input  logic [31:0]        i_inst_write_data,
  output logic [31:0]        o_pc,
  output logic [31:0]        o_pc4,
  output logic [31:0]        o_instruction,
  output logic               o_halted
);

  localparam int DEPTH = 2 ** NB_ADDR;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic [31:0] r_instruction;
  logic        r_halted;

  logic [31:0] w_fetch;
  logic [31:0] w_pc_plus4;

  // Write port ignores reset/enable/halt so the debug unit can load at any time.
  always_ff @(posedge i_clk) begin
    if (i_inst_write_enable) begin
      r_mem[i_inst_write_addr] <= i_inst_write_data;
    end
  end

  // Asynchronous read; same-cycle write therefore returns the old word.
  assign w_fetch    = r_mem[r_pc[NB_ADDR+1:2]];
  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= 32'd0;
      r_pc4         <= 32'd0;
      r_instruction <= 32'd0;
      r_halted      <= 1'b0;
    end else if (i_enable && !r_halted && !i_stall) begin
      if (i_halt) begin
        r_halted      <= 1'b1;
        r_pc4         <= 32'd0;
        r_instruction <= NOP;
      end else if (i_jump) begin
        // No delay slot: the wrong-path fetch is squashed into a bubble.
        r_pc          <= i_jump_addr;
        r_pc4         <= 32'd0;
        r_instruction <= NOP;
      end else begin
        r_pc          <= w_pc_plus4;
        r_pc4         <= w_pc_plus4;
        r_instruction <= w_fetch;
      end
    end
  end

  assign o_pc          = r_pc;
  assign o_pc4         = r_pc4;
  assign o_instruction = r_instruction;
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: one default-size instance for the main
// scenarios and one NB_ADDR=2 instance for address wrap and same-cycle write.
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A (NB_ADDR = 8)
  logic        a_reset, a_enable, a_stall, a_jump, a_halt, a_we;
  logic [31:0] a_jump_addr, a_wdata;
  logic [7:0]  a_waddr;
  logic [31:0] a_pc, a_pc4, a_inst;
  logic        a_halted;

  // Instance B (NB_ADDR = 2)
  logic        b_reset, b_enable, b_stall, b_jump, b_halt, b_we;
  logic [31:0] b_jump_addr, b_wdata;
  logic [1:0]  b_waddr;
  logic [31:0] b_pc, b_pc4, b_inst;
  logic        b_halted;

  instruction_fetch #(.NB_ADDR(8), .NOP(32'h00000000)) u_dut_a (
    .i_clk(clk), .i_reset(a_reset), .i_enable(a_enable), .i_stall(a_stall),
    .i_jump(a_jump), .i_jump_addr(a_jump_addr), .i_halt(a_halt),
    .i_inst_write_enable(a_we), .i_inst_write_addr(a_waddr), .i_inst_write_data(a_wdata),
    .o_pc(a_pc), .o_pc4(a_pc4), .o_instruction(a_inst), .o_halted(a_halted)
  );

  instruction_fetch #(.NB_ADDR(2), .NOP(32'h00000000)) u_dut_b (
    .i_clk(clk), .i_reset(b_reset), .i_enable(b_enable), .i_stall(b_stall),
    .i_jump(b_jump), .i_jump_addr(b_jump_addr), .i_halt(b_halt),
    .i_inst_write_enable(b_we), .i_inst_write_addr(b_waddr), .i_inst_write_data(b_wdata),
    .o_pc(b_pc), .o_pc4(b_pc4), .o_instruction(b_inst), .o_halted(b_halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic [31:0] inst);
    $display("A %-12s pc=%08h pc4=%08h inst=%08h halted=%0b", tag, a_pc, a_pc4, a_inst, a_halted);
    check({tag, ".pc"}, a_pc, pc);
    check({tag, ".pc4"}, a_pc4, pc4);
    check({tag, ".inst"}, a_inst, inst);
  endtask

  task automatic check_b(input string tag, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic [31:0] inst);
    $display("B %-12s pc=%08h pc4=%08h inst=%08h", tag, b_pc, b_pc4, b_inst);
    check({tag, ".pc"}, b_pc, pc);
    check({tag, ".pc4"}, b_pc4, pc4);
    check({tag, ".inst"}, b_inst, inst);
  endtask

  task automatic write_a(input logic [7:0] addr, input logic [31:0] data);
    a_we = 1'b1; a_waddr = addr; a_wdata = data;
    step();
    a_we = 1'b0;
  endtask

  task automatic write_b(input logic [1:0] addr, input logic [31:0] data);
    b_we = 1'b1; b_waddr = addr; b_wdata = data;
    step();
    b_we = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_enable = 1'b0; a_stall = 1'b0; a_jump = 1'b0; a_halt = 1'b0;
    a_jump_addr = 32'd0; a_we = 1'b0; a_waddr = 8'd0; a_wdata = 32'd0;
    b_reset = 1'b1; b_enable = 1'b0; b_stall = 1'b0; b_jump = 1'b0; b_halt = 1'b0;
    b_jump_addr = 32'd0; b_we = 1'b0; b_waddr = 2'd0; b_wdata = 32'd0;
    #1;

    // Program load while reset is held.
    write_a(8'd0, 32'h11);
    write_a(8'd1, 32'h22);
    write_a(8'd2, 32'h33);
    write_a(8'd3, 32'h44);
    write_a(8'd4, 32'h55);
    write_a(8'd16, 32'hAB);
    write_a(8'd17, 32'hAC);
    step();
    check_a("reset", 32'd0, 32'd0, 32'd0);
    check("reset.halted", {31'd0, a_halted}, 32'd0);

    // Sequential fetch.
    a_reset = 1'b0; a_enable = 1'b1;
    step(); check_a("seq0", 32'd4, 32'd4, 32'h11);
    step(); check_a("seq1", 32'd8, 32'd8, 32'h22);

    // Two-cycle stall.
    a_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); check_a("stall", 32'd8, 32'd8, 32'h22);
    end
    a_stall = 1'b0;
    step(); check_a("post_stall", 32'd12, 32'd12, 32'h33);

    // Enable low for 5 cycles with a memory write inside the window.
    a_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a_we = 1'b1; a_waddr = 8'd5; a_wdata = 32'h66;
      end
      step();
      a_we = 1'b0;
      check_a("en_low", 32'd12, 32'd12, 32'h33);
    end
    a_enable = 1'b1;
    step(); check_a("seq3", 32'd16, 32'd16, 32'h44);
    step(); check_a("seq4", 32'd20, 32'd20, 32'h55);
    step(); check_a("seq5_wr", 32'd24, 32'd24, 32'h66);

    // Stall together with jump: jump ignored.
    a_stall = 1'b1; a_jump = 1'b1; a_jump_addr = 32'h40;
    step(); check_a("stall_jump", 32'd24, 32'd24, 32'h66);
    a_stall = 1'b0;
    step(); check_a("jump_bubble", 32'h40, 32'd0, 32'd0);
    a_jump = 1'b0;
    step(); check_a("jump_target", 32'h44, 32'h44, 32'hAB);
    step(); check_a("jump_next", 32'h48, 32'h48, 32'hAC);

    // Halt, then try to jump for 10 cycles.
    a_halt = 1'b1;
    step(); check_a("halt", 32'h48, 32'd0, 32'd0);
    check("halt.halted", {31'd0, a_halted}, 32'd1);
    a_halt = 1'b0; a_jump = 1'b1; a_jump_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
      step(); check_a("halted_hold", 32'h48, 32'd0, 32'd0);
    end
    check("halted_sticky", {31'd0, a_halted}, 32'd1);
    a_reset = 1'b1;
    step(); check_a("halt_reset", 32'd0, 32'd0, 32'd0);
    check("reset_clears_halt", {31'd0, a_halted}, 32'd0);
    a_reset = 1'b0; a_jump = 1'b0; a_enable = 1'b0;

    // Instance B: wrap and same-cycle write.
    write_b(2'd0, 32'hA0);
    write_b(2'd1, 32'hA1);
    write_b(2'd2, 32'hA2);
    write_b(2'd3, 32'hA3);
    b_reset = 1'b0; b_enable = 1'b1;
    step(); check_b("b_seq0", 32'd4, 32'd4, 32'hA0);
    // Fetching PC=4 (mem[1]) while writing mem[1]: old word latched.
    b_we = 1'b1; b_waddr = 2'd1; b_wdata = 32'hB1;
    step(); b_we = 1'b0;
    check_b("b_same_wr", 32'd8, 32'd8, 32'hA1);
    step(); check_b("b_seq2", 32'd12, 32'd12, 32'hA2);
    step(); check_b("b_seq3", 32'h10, 32'h10, 32'hA3);
    step(); check_b("b_wrap", 32'h14, 32'h14, 32'hA0);
    step(); check_b("b_new_word", 32'h18, 32'h18, 32'hB1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
